gbt_link_sequencer: RTL and testbench
=====================================

GBT_LINK_SEQUENCER -- requirements
Module: gbt_link_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter LOS_DEBOUNCE, default 1024, meaning consecutive sfp_los_i=0 cycles before link bring-up.
REQ-003 SHALL have parameter RESET_CYCLES, default 256, meaning gbt_general_reset_o pulse length in GEN_RESET.
REQ-004 SHALL have parameter BITSLIP_CYCLES, default 4, meaning bitslip_rst_o pulse length.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 400000, meaning cycles allowed in WAIT_LOCK (10 ms at 40 MHz).
REQ-006 SHALL have parameter STABLE_CYCLES, default 64, meaning consecutive link_ready_i=1 cycles to declare link up.
REQ-007 SHALL have parameter MAX_RETRIES, default 7, range 1..15, meaning bitslip retries before FAILED.
REQ-008 SHALL have port ClkRs_ix  input  ckrs_t  (.clk = 40 MHz frame clock, .reset = synchronous active-high reset).
REQ-009 SHALL have port enable_i  input  1  sequencer enable.
REQ-010 SHALL have port sfp_los_i  input  1  SFP loss of signal (asynchronous source, synchronised internally with 2 flops).
REQ-011 SHALL have port link_ready_i  input  1  GBT bank link ready.
REQ-012 SHALL have port manual_reset_i  input  1  single-cycle restart request.
REQ-013 SHALL have port gbt_general_reset_o  output  1  GBT bank general reset.
REQ-014 SHALL have port bitslip_rst_o  output  1  GBT RX bitslip reset-on-even request.
REQ-015 SHALL have port link_up_o / link_fail_o  output  1 each  status flags.
REQ-016 SHALL have port state_o  output  3  encoded state; retry_cnt_o  output  4; los_event_cnt_o  output  8.

Function
REQ-017 SHALL encode states IDLE=0, WAIT_LOS=1, GEN_RESET=2, WAIT_LOCK=3, BITSLIP_RST=4, LINK_UP=5, FAILED=6; all outputs registered, one cycle after state entry.
REQ-018 SHALL apply global priority every cycle: enable_i=0 -> IDLE; else synchronised LOS=1 in GEN_RESET/WAIT_LOCK/BITSLIP_RST/LINK_UP -> WAIT_LOS; else manual_reset_i=1 in any non-IDLE state -> GEN_RESET with retry_cnt cleared; else per-state rules.
REQ-019 IDLE: enable_i=1 -> WAIT_LOS.
REQ-020 WAIT_LOS: counter increments while LOS=0, clears on LOS=1; reaching LOS_DEBOUNCE -> GEN_RESET, retry_cnt cleared.
REQ-021 GEN_RESET: after exactly RESET_CYCLES cycles -> WAIT_LOCK.
REQ-022 WAIT_LOCK: timeout counter and stable counter start at 0 on entry; stable counter clears on link_ready_i=0; reaching STABLE_CYCLES -> LINK_UP (takes precedence over simultaneous timeout).
REQ-023 WAIT_LOCK timeout: when LOCK_TIMEOUT reached, retry_cnt<MAX_RETRIES -> BITSLIP_RST with retry_cnt+1; else -> FAILED.
REQ-024 BITSLIP_RST: after exactly BITSLIP_CYCLES cycles -> WAIT_LOCK.
REQ-025 LINK_UP: link_ready_i=0 -> WAIT_LOCK (retry_cnt kept); LOS=1 -> WAIT_LOS and los_event_cnt+1, saturating at 255.
REQ-026 FAILED: held until manual_reset_i or enable_i=0.
REQ-027 gbt_general_reset_o SHALL be 1 in IDLE, WAIT_LOS, GEN_RESET, FAILED; 0 otherwise.
REQ-028 bitslip_rst_o SHALL be 1 only in BITSLIP_RST; link_up_o only in LINK_UP; link_fail_o only in FAILED.
REQ-029 All counters SHALL be sized by $clog2 of their parameter + 1 and never wrap.

Reset
REQ-030 On ClkRs_ix.reset=1: state IDLE, gbt_general_reset_o=1, all other outputs 0, all counters 0, LOS synchroniser set to 1.
REQ-031 Reset asserted mid-operation SHALL override every transition in the same cycle; los_event_cnt_o cleared only by reset.

Verification (LOS_DEBOUNCE=16, RESET_CYCLES=8, BITSLIP_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=4, MAX_RETRIES=2)
REQ-032 enable=1, LOS 1->0, link_ready=1 after GEN_RESET -> gbt_general_reset_o high 8 cycles, link_up_o=1 after 4 stable cycles, state_o=5.
REQ-033 link_ready held 0 -> two bitslip_rst_o pulses of 4 cycles, retry_cnt_o 1 then 2, then link_fail_o=1, state_o=6; manual_reset_i -> state_o=2, retry_cnt_o=0.
REQ-034 LOS glitch of 1 cycle at debounce count 15 -> counter restarts, GEN_RESET only after 16 further clean cycles.
REQ-035 In LINK_UP, LOS=1 and link_ready=0 same cycle -> WAIT_LOS, los_event_cnt_o=1; 256 LOS events -> saturates at 255.
REQ-036 enable_i=0 during BITSLIP_RST -> IDLE next cycle, bitslip_rst_o=0, gbt_general_reset_o=1; ClkRs_ix.reset in LINK_UP -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/gbt_link_sequencer.sv
// GBT link bring-up sequencer: waits for a clean SFP signal, resets the GBT
// bank, waits for lock (with bitslip retries) and reports link status.

package gbt_link_sequencer_pkg;
    // Clock/reset bundle shared by frame-clock blocks
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_link_sequencer
    import gbt_link_sequencer_pkg::*;
#(
    parameter int LOS_DEBOUNCE   = 1024,
    parameter int RESET_CYCLES   = 256,
    parameter int BITSLIP_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 400000,
    parameter int STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES    = 7
) (
    input  ckrs_t       ClkRs_ix,
    input  logic        enable_i,
    input  logic        sfp_los_i,
    input  logic        link_ready_i,
    input  logic        manual_reset_i,
    output logic        gbt_general_reset_o,
    output logic        bitslip_rst_o,
    output logic        link_up_o,
    output logic        link_fail_o,
    output logic [2:0]  state_o,
    output logic [3:0]  retry_cnt_o,
    output logic [7:0]  los_event_cnt_o
);

    localparam int PUL_MAX = (RESET_CYCLES > BITSLIP_CYCLES) ? RESET_CYCLES : BITSLIP_CYCLES;
    localparam int DEB_W   = $clog2(LOS_DEBOUNCE) + 1;
    localparam int PUL_W   = $clog2(PUL_MAX) + 1;
    localparam int TO_W    = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STB_W   = $clog2(STABLE_CYCLES) + 1;

    // Terminal counts: a counter equal to *_LAST means this is the last cycle
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(LOS_DEBOUNCE - 1);
    localparam logic [PUL_W-1:0] RST_LAST = PUL_W'(RESET_CYCLES - 1);
    localparam logic [PUL_W-1:0] BS_LAST  = PUL_W'(BITSLIP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_LOS    = 3'd1,
        GEN_RESET   = 3'd2,
        WAIT_LOCK   = 3'd3,
        BITSLIP_RST = 3'd4,
        LINK_UP     = 3'd5,
        FAILED      = 3'd6
    } state_t;

    logic             clk;
    logic             rst;
    logic [1:0]       los_sync;
    logic             los_s;
    state_t           state, nxt;
    logic [3:0]       retry_cnt, retry_nxt;
    logic [7:0]       los_evt;
    logic             evt_inc;
    logic             restart;
    logic             stay;
    logic [DEB_W-1:0] deb_cnt;
    logic [PUL_W-1:0] pul_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [STB_W-1:0] stb_cnt;

    assign clk   = ClkRs_ix.clk;
    assign rst   = ClkRs_ix.reset;
    assign los_s = los_sync[1];
    // Counters run only while the state is held; any entry (including a
    // manual restart into GEN_RESET from GEN_RESET) starts them from zero.
    assign stay  = (nxt == state) && !restart;

    // Two-flop synchroniser for the asynchronous LOS input; presets to "lost"
    always_ff @(posedge clk) begin
        if (rst) los_sync <= 2'b11;
        else     los_sync <= {los_sync[0], sfp_los_i};
    end

    // Next-state decision: enable, then LOS, then manual restart, then per-state
    always_comb begin
        nxt       = state;
        retry_nxt = retry_cnt;
        evt_inc   = 1'b0;
        restart   = 1'b0;
        if (!enable_i) begin
            nxt = IDLE;
        end else if (los_s && (state == GEN_RESET || state == WAIT_LOCK ||
                               state == BITSLIP_RST || state == LINK_UP)) begin
            nxt     = WAIT_LOS;
            evt_inc = (state == LINK_UP);
        end else if (manual_reset_i && state != IDLE) begin
            nxt       = GEN_RESET;
            retry_nxt = '0;
            restart   = 1'b1;
        end else begin
            case (state)
                IDLE:     nxt = WAIT_LOS;
                WAIT_LOS: begin
                    if (!los_s && deb_cnt == DEB_LAST) begin
                        nxt       = GEN_RESET;
                        retry_nxt = '0;
                    end
                end
                GEN_RESET: begin
                    if (pul_cnt == RST_LAST) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Reaching stability wins over a timeout in the same cycle
                    if (link_ready_i && stb_cnt == STB_LAST) begin
                        nxt = LINK_UP;
                    end else if (to_cnt == TO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            nxt       = BITSLIP_RST;
                            retry_nxt = retry_cnt + 4'd1;
                        end else begin
                            nxt = FAILED;
                        end
                    end
                end
                BITSLIP_RST: begin
                    if (pul_cnt == BS_LAST) nxt = WAIT_LOCK;
                end
                LINK_UP: begin
                    if (!link_ready_i) nxt = WAIT_LOCK;
                end
                FAILED:  nxt = FAILED;
                default: nxt = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            retry_cnt           <= '0;
            los_evt             <= '0;
            deb_cnt             <= '0;
            pul_cnt             <= '0;
            to_cnt              <= '0;
            stb_cnt             <= '0;
            gbt_general_reset_o <= 1'b1;
            bitslip_rst_o       <= 1'b0;
            link_up_o           <= 1'b0;
            link_fail_o         <= 1'b0;
        end else begin
            state     <= nxt;
            retry_cnt <= retry_nxt;
            if (evt_inc && los_evt != 8'hFF) los_evt <= los_evt + 8'd1;
            deb_cnt <= (stay && state == WAIT_LOS && !los_s) ? deb_cnt + 1'b1 : '0;
            pul_cnt <= (stay && (state == GEN_RESET || state == BITSLIP_RST)) ? pul_cnt + 1'b1 : '0;
            to_cnt  <= (stay && state == WAIT_LOCK) ? to_cnt + 1'b1 : '0;
            stb_cnt <= (stay && state == WAIT_LOCK && link_ready_i) ? stb_cnt + 1'b1 : '0;
            gbt_general_reset_o <= (nxt == IDLE) || (nxt == WAIT_LOS) ||
                                   (nxt == GEN_RESET) || (nxt == FAILED);
            bitslip_rst_o       <= (nxt == BITSLIP_RST);
            link_up_o           <= (nxt == LINK_UP);
            link_fail_o         <= (nxt == FAILED);
        end
    end

    assign state_o         = state;
    assign retry_cnt_o     = retry_cnt;
    assign los_event_cnt_o = los_evt;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Directed bench for gbt_link_sequencer with small parameters.
module tb_gbt_link_sequencer;

    logic clk = 1'b0, rst = 1'b1;
    logic en = 1'b0, los = 1'b1, lr = 1'b0, mr = 1'b0;
    logic gen, bs, up, fail;
    logic [2:0] st;
    logic [3:0] rty;
    logic [7:0] evt;
    int n_chk = 0, n_pass = 0;

    gbt_link_sequencer #(
        .LOS_DEBOUNCE(16), .RESET_CYCLES(8), .BITSLIP_CYCLES(4),
        .LOCK_TIMEOUT(100), .STABLE_CYCLES(4), .MAX_RETRIES(2)
    ) dut (
        .ClkRs_ix({clk, rst}),
        .enable_i(en),
        .sfp_los_i(los),
        .link_ready_i(lr),
        .manual_reset_i(mr),
        .gbt_general_reset_o(gen),
        .bitslip_rst_o(bs),
        .link_up_o(up),
        .link_fail_o(fail),
        .state_o(st),
        .retry_cnt_o(rty),
        .los_event_cnt_o(evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // {gen, bs, up, fail}
    function automatic int flags();
        return int'({gen, bs, up, fail});
    endfunction

    task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && st != s; i++) step(1);
        chk(tag, int'(st), int'(s));
    endtask

    task automatic dwell(input logic [2:0] s, output int n);
        n = 0;
        while (st == s && n < 1000) begin n++; step(1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // reset values
        step(2);
        chk("rst_state", int'(st), 0);
        chk("rst_flags", flags(), 4'b1000);
        chk("rst_retry", int'(rty), 0);
        chk("rst_evt", int'(evt), 0);
        rst = 1'b0;
        step(1);
        chk("idle_en0", int'(st), 0);
        en = 1'b1;
        step(1);
        chk("wait_los", int'(st), 1);

        // LOS glitch at debounce count 15 restarts the debounce
        los = 1'b0; step(15);
        los = 1'b1; step(1);
        los = 1'b0; step(2);
        chk("glitch_hold", int'(st), 1);
        step(15);
        chk("glitch_hold2", int'(st), 1);
        step(1);
        chk("deb_done", int'(st), 2);
        chk("genrst_retry", int'(rty), 0);

        // bring-up: 8 cycles of general reset, 4 stable cycles to link up
        lr = 1'b1;
        dwell(3'd2, n);
        chk("genrst_len", n, 8);
        chk("lock_flags", flags(), 4'b0000);
        dwell(3'd3, n);
        chk("stable_len", n, 4);
        chk("link_up_st", int'(st), 5);
        chk("link_up_flags", flags(), 4'b0010);

        // LOS and link_ready drop coincide at the decision point
        los = 1'b1; step(2);
        chk("los_sync_lag", int'(st), 5);
        lr = 1'b0; step(1);
        chk("los_pri", int'(st), 1);
        chk("los_evt1", int'(evt), 1);
        chk("wait_los_flags", flags(), 4'b1000);

        // drive the LOS event counter to saturation
        for (int k = 0; k < 254; k++) begin
            los = 1'b0; lr = 1'b1;
            wait_st(3'd5, 100, "evt_up");
            los = 1'b1; step(3);
        end
        chk("los_evt255", int'(evt), 255);
        los = 1'b0; lr = 1'b1;
        wait_st(3'd5, 100, "evt_up_last");
        los = 1'b1; step(3);
        chk("los_evt_state", int'(st), 1);
        chk("los_sat", int'(evt), 255);

        // no lock: two bitslip retries then FAILED
        los = 1'b0; lr = 1'b0;
        wait_st(3'd2, 100, "to_genrst");
        wait_st(3'd3, 20, "to_lock");
        dwell(3'd3, n);
        chk("lock_to_len", n, 100);
        chk("bs1_state", int'(st), 4);
        chk("bs1_retry", int'(rty), 1);
        chk("bs1_flags", flags(), 4'b0100);
        n = 0;
        while (bs && n < 50) begin n++; step(1); end
        chk("bs_len", n, 4);
        chk("bs_back_lock", int'(st), 3);
        wait_st(3'd4, 150, "bs2");
        chk("bs2_retry", int'(rty), 2);
        wait_st(3'd6, 150, "failed");
        chk("fail_flags", flags(), 4'b1001);
        chk("fail_retry", int'(rty), 2);
        step(5);
        chk("fail_hold", int'(st), 6);
        mr = 1'b1; step(1); mr = 1'b0;
        chk("manual_state", int'(st), 2);
        chk("manual_retry", int'(rty), 0);

        // enable drop during bitslip
        wait_st(3'd4, 200, "bs_again");
        step(1);
        en = 1'b0; step(1);
        chk("dis_state", int'(st), 0);
        chk("dis_flags", flags(), 4'b1000);

        // reset while link is up
        en = 1'b1; lr = 1'b1;
        wait_st(3'd5, 200, "relink");
        rst = 1'b1; step(1);
        chk("rst2_state", int'(st), 0);
        chk("rst2_flags", flags(), 4'b1000);
        chk("rst2_retry", int'(rty), 0);
        chk("rst2_evt", int'(evt), 0);
        // synchroniser preset to LOS=1 delays debounce by one cycle
        rst = 1'b0; step(17);
        chk("sync_preset", int'(st), 1);
        step(1);
        chk("deb_after_rst", int'(st), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
